tile_line_fetch: RTL and testbench
==================================

TILE_LINE_FETCH -- requirements
Module: tile_line_fetch

Interface
REQ-001 Parameter TILE_W, default 8, tile width and height in pixels (power of two).
REQ-002 Parameter TILES_PER_LINE, default 28, tiles per scanline.
REQ-003 Parameter BPP, default 2, bits per pixel in tile ROM (1, 2 or 4).
REQ-004 Parameters TILE_BASE = 16'h4000 and PAL_BASE = 16'h4400, video RAM bases for tile codes and palette codes.
REQ-005 clk  in  1  sole clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 line_start  in  1  one-cycle pulse that begins a fill for line row and swaps the display buffers.
REQ-008 row  in  9  scanline being filled, sampled on line_start.
REQ-009 ram_req / ram_addr  out  1 / 16  video RAM read request and address.
REQ-010 ram_valid / ram_rdata  in  1 / 8  read completion strobe and data.
REQ-011 rom_addr  out  8+log2(TILE_W)+log2(TILE_W*BPP/8)  tile ROM address.
REQ-012 rom_data  in  8  tile ROM data, valid exactly 1 cycle after rom_addr.
REQ-013 pix_col  in  10  display column; blank  in  1  blanking.
REQ-014 color_index  out  8  {palette code[5:0], pixel data (zero-extended to 2 bits)}, registered.
REQ-015 busy  out  1 fill in progress; line_late  out  1 one-cycle overrun pulse.

Function
REQ-016 FSM states IDLE, RD_TILE, RD_PAL, RD_ROM, WRITE; reset and completion go to IDLE.
REQ-017 IDLE -> RD_TILE on line_start; tile counter t = 0; row latched.
REQ-018 RD_TILE: ram_addr = TILE_BASE + (row/TILE_W)*TILES_PER_LINE + t, ram_req held high until ram_valid; tile code latched from ram_rdata; -> RD_PAL.
REQ-019 RD_PAL: same handshake at PAL_BASE + same offset; low 6 bits latched as palette code; -> RD_ROM.
REQ-020 ram_addr shall not change while ram_req is high; ram_req drops the cycle after ram_valid; ram_valid while ram_req low is ignored.
REQ-021 RD_ROM: issue B = TILE_W*BPP/8 consecutive addresses {tile code, row mod TILE_W, byte b}, one per cycle; capture each byte one cycle later.
REQ-022 Within a byte, pixel p occupies bits [BPP*(8/BPP-1-p) +: BPP] (MSB first); byte b holds pixels b*(8/BPP) onward.
REQ-023 WRITE: all TILE_W pixels of tile t written to back buffer entries t*TILE_W .. t*TILE_W+TILE_W-1 in one cycle; t increments; -> RD_TILE, or -> IDLE after t = TILES_PER_LINE-1.
REQ-024 Line buffer: two banks of TILE_W*TILES_PER_LINE entries of 6+BPP bits; back bank filled, front bank displayed; banks swap on every line_start.
REQ-025 color_index = front[pix_col] one cycle after pix_col; 8'h00 if blank or pix_col >= TILE_W*TILES_PER_LINE in that prior cycle.
REQ-026 busy high from cycle after line_start until the cycle after the final WRITE.
REQ-027 line_start while busy: pulse line_late once, swap banks anyway, abandon fill (outstanding RAM request completes but data discarded), restart at t = 0 with new row.
REQ-028 Tile counter and address arithmetic 16-bit wrap; no saturation.

Reset
REQ-029 On rst: state IDLE, t = 0, ram_req = 0, ram_addr = 0, rom_addr = 0, busy = 0, line_late = 0, color_index = 0, front bank select = 0; buffer contents undefined until first complete fill.
REQ-030 rst mid-fill abandons the fill within the same cycle; the next line_start begins a fresh fill.

Verification
REQ-031 row = 16, RAM[16'h4038] = 8'h05, RAM[16'h4438] = 8'h03, ROM byte pair {8'h1B, 8'hE4} for tile 5 row 0 -> after swap, pix_col 0..7 give 8'h0C,0D,0E,0F,0F,0E,0D,0C.
REQ-032 ram_valid delayed 0, 1 and 7 cycles -> ram_addr stable throughout, each fill completes, buffer contents identical.
REQ-033 line_start reasserted at tile 10 of a fill -> line_late one-cycle pulse, fill restarts at tile 0 with new row address, busy stays high.
REQ-034 blank = 1 or pix_col = 224 -> color_index = 8'h00 next cycle.
REQ-035 rst asserted during RD_ROM -> next cycle ram_req = 0, busy = 0, color_index = 0; subsequent fill correct.
REQ-036 Parameter sweep TILE_W = 16, BPP = 4, TILES_PER_LINE = 4 -> B = 8 ROM reads per tile, 64 pixels match a reference model.

Source files
------------

// File: rtl/tile_line_fetch.sv
// tile_line_fetch: fetches one scanline of tile pixels from video RAM and tile ROM into the back bank of a
// double-buffered line buffer while the front bank is displayed.
module tile_line_fetch #(
  parameter int TILE_W = 8,
  parameter int TILES_PER_LINE = 28,
  parameter int BPP = 2,
  parameter logic [15:0] TILE_BASE = 16'h4000,
  parameter logic [15:0] PAL_BASE = 16'h4400,
  localparam int B = TILE_W * BPP / 8,
  localparam int RA_W = 8 + $clog2(TILE_W) + $clog2(B)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            line_start,
  input  logic [8:0]      row,
  output logic            ram_req,
  output logic [15:0]     ram_addr,
  input  logic            ram_valid,
  input  logic [7:0]      ram_rdata,
  output logic [RA_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  input  logic [9:0]      pix_col,
  input  logic            blank,
  output logic [7:0]      color_index,
  output logic            busy,
  output logic            line_late
);
  localparam int N = TILE_W * TILES_PER_LINE;
  localparam int TW_L = $clog2(TILE_W);
  localparam int BC_W = $clog2(B + 1);
  localparam int IW = $clog2(N);
  localparam int EW = 6 + BPP;
  localparam int PX_W = BPP < 2 ? 2 : BPP;
  localparam int PW = TILE_W * BPP;
  typedef enum logic [2:0] {IDLE, RD_TILE, RD_PAL, RD_ROM, WRITE} state_t;
  state_t state_q, state_d;
  logic [15:0] t_q, t_d, ram_addr_q, ram_addr_d, off;
  logic [8:0] row_q, row_d;
  logic [7:0] tile_q, tile_d, ci_q, ci_d;
  logic [5:0] pal_q, pal_d;
  logic [BC_W-1:0] b_q, b_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [RA_W-1:0] rom_addr_q, rom_addr_d;
  logic ram_req_q, ram_req_d, drain_q, drain_d, front_q, front_d;
  logic busy_q, busy_d, line_late_q, line_late_d;
  logic [EW-1:0] mem [2][N];
  logic [EW-1:0] rd_e;
  function automatic logic [RA_W-1:0] raddr(input logic [7:0] code, input logic [TW_L-1:0] rm, input int bn);
    return RA_W'(int'(code) * TILE_W * B + int'(rm) * B + bn);
  endfunction
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    row_d = row_q;
    tile_d = tile_q;
    pal_d = pal_q;
    b_d = b_q;
    pix_d = pix_q;
    ram_req_d = ram_req_q;
    ram_addr_d = ram_addr_q;
    rom_addr_d = rom_addr_q;
    drain_d = drain_q;
    front_d = front_q ^ line_start;
    line_late_d = line_start && state_q != IDLE;
    off = 16'(row_q >> TW_L) * 16'(TILES_PER_LINE) + t_q;
    case (state_q)
      RD_TILE:
        if (!ram_req_q) begin
          ram_req_d = 1'b1;
          ram_addr_d = TILE_BASE + off;
        end else if (ram_valid) begin
          ram_req_d = 1'b0;
          drain_d = 1'b0;
          tile_d = ram_rdata;
          state_d = drain_q ? RD_TILE : RD_PAL;
        end
      RD_PAL:
        if (!ram_req_q) begin
          ram_req_d = 1'b1;
          ram_addr_d = PAL_BASE + off;
        end else if (ram_valid) begin
          ram_req_d = 1'b0;
          pal_d = ram_rdata[5:0];
          b_d = '0;
          rom_addr_d = raddr(tile_q, row_q[TW_L-1:0], 0);
          state_d = RD_ROM;
        end
      RD_ROM: begin
        // rom_data seen with count b belongs to the address issued at count b-1
        b_d = b_q + BC_W'(1);
        if (b_q != '0) pix_d[8 * (B - int'(b_q)) +: 8] = rom_data;
        if (int'(b_q) < B - 1) rom_addr_d = raddr(tile_q, row_q[TW_L-1:0], int'(b_q) + 1);
        if (int'(b_q) == B) state_d = WRITE;
      end
      WRITE: begin
        t_d = t_q + 16'd1;
        state_d = t_q == 16'(TILES_PER_LINE - 1) ? IDLE : RD_TILE;
      end
      default: ;
    endcase
    // a restart keeps any outstanding request alive so its completion can be drained
    if (line_start) begin
      state_d = RD_TILE;
      t_d = '0;
      row_d = row;
      ram_req_d = ram_req_q && !ram_valid;
      drain_d = ram_req_q && !ram_valid;
      ram_addr_d = ram_addr_q;
    end
    busy_d = state_d != IDLE;
    rd_e = mem[front_q][pix_col[IW-1:0]];
    ci_d = blank || pix_col >= 10'(N) ? 8'h00 : 8'({rd_e[EW-1:BPP], PX_W'(rd_e[BPP-1:0])});
  end
  always_ff @(posedge clk)
    if (state_q == WRITE && !line_start && !rst)
      for (int i = 0; i < TILE_W; i++)
        mem[~front_q][IW'(int'(t_q) * TILE_W + i)] <= {pal_q, pix_q[PW - BPP * (i + 1) +: BPP]};
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      t_q <= '0;
      row_q <= '0;
      tile_q <= '0;
      pal_q <= '0;
      b_q <= '0;
      pix_q <= '0;
      ram_req_q <= 1'b0;
      ram_addr_q <= '0;
      rom_addr_q <= '0;
      drain_q <= 1'b0;
      front_q <= 1'b0;
      busy_q <= 1'b0;
      line_late_q <= 1'b0;
      ci_q <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      row_q <= row_d;
      tile_q <= tile_d;
      pal_q <= pal_d;
      b_q <= b_d;
      pix_q <= pix_d;
      ram_req_q <= ram_req_d;
      ram_addr_q <= ram_addr_d;
      rom_addr_q <= rom_addr_d;
      drain_q <= drain_d;
      front_q <= front_d;
      busy_q <= busy_d;
      line_late_q <= line_late_d;
      ci_q <= ci_d;
    end
  assign ram_req = ram_req_q;
  assign ram_addr = ram_addr_q;
  assign rom_addr = rom_addr_q;
  assign color_index = ci_q;
  assign busy = busy_q;
  assign line_late = line_late_q;
endmodule

// File: tb/tb_tile_line_fetch.sv
// tb_tile_line_fetch: directed checks of the default tile fetcher and a TILE_W=16/BPP=4/4-tile variant
module tb_tile_line_fetch;
  logic clk = 1'b0, rst = 1'b1;
  logic line_start_a = 1'b0, ram_valid_a = 1'b0, blank_a = 1'b0, ram_req_a, busy_a, late_a;
  logic [8:0] row_a = '0;
  logic [15:0] ram_addr_a;
  logic [7:0] ram_rdata_a = '0, rom_data_a = '0, ci_a;
  logic [11:0] rom_addr_a;
  logic [9:0] pix_col_a = '0;
  logic line_start_b = 1'b0, ram_valid_b = 1'b0, blank_b = 1'b0, ram_req_b, busy_b, late_b;
  logic [8:0] row_b = '0;
  logic [15:0] ram_addr_b;
  logic [7:0] ram_rdata_b = '0, rom_data_b = '0, ci_b;
  logic [14:0] rom_addr_b;
  logic [9:0] pix_col_b = '0;
  int errors = 0, checks = 0, stab_err = 0, late_cnt = 0, dly_a = 0, dly_b = 2, cnt_a = 0, cnt_b = 0;
  logic pa_req = 1'b0, pb_req = 1'b0;
  logic [15:0] pa_addr = '0, pb_addr = '0;
  logic [7:0] hand [8] = '{8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h0F, 8'h0E, 8'h0D, 8'h0C};

  always #5 clk = ~clk;

  tile_line_fetch dut_a (
    .clk(clk), .rst(rst), .line_start(line_start_a), .row(row_a),
    .ram_req(ram_req_a), .ram_addr(ram_addr_a), .ram_valid(ram_valid_a), .ram_rdata(ram_rdata_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .pix_col(pix_col_a), .blank(blank_a),
    .color_index(ci_a), .busy(busy_a), .line_late(late_a));

  tile_line_fetch #(.TILE_W(16), .TILES_PER_LINE(4), .BPP(4)) dut_b (
    .clk(clk), .rst(rst), .line_start(line_start_b), .row(row_b),
    .ram_req(ram_req_b), .ram_addr(ram_addr_b), .ram_valid(ram_valid_b), .ram_rdata(ram_rdata_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .pix_col(pix_col_b), .blank(blank_b),
    .color_index(ci_b), .busy(busy_b), .line_late(late_b));

  function automatic logic [7:0] tile_fn(int a);
    return 8'(a - 'h4038 + 5);
  endfunction
  function automatic logic [7:0] pal_fn(int a);
    return 8'(a - 'h4438 + 3) | 8'hC0;
  endfunction
  function automatic logic [7:0] ram_fn(logic [15:0] a);
    return a >= 16'h4400 ? pal_fn(int'(a)) : tile_fn(int'(a));
  endfunction
  function automatic logic [7:0] rom_fn(int a);
    return a == 80 ? 8'h1B : a == 81 ? 8'hE4 : 8'(a * 37 + 11);
  endfunction
  function automatic logic [7:0] exp_ci(int tw, int tpl, int bpp, int r, int c);
    int b = tw * bpp / 8, ppb = 8 / bpp, off = (r / tw) * tpl + c / tw, k = c % tw, px;
    logic [7:0] code = tile_fn('h4000 + off), pal = pal_fn('h4400 + off) & 8'h3F, by;
    by = rom_fn(int'(code) * tw * b + (r % tw) * b + k / ppb);
    px = (int'(by) >> (bpp * (ppb - 1 - k % ppb))) & ((1 << bpp) - 1);
    return 8'((int'(pal) << (bpp < 2 ? 2 : bpp)) | px);
  endfunction

  always @(posedge clk) rom_data_a <= rom_fn(int'(rom_addr_a));
  always @(posedge clk) rom_data_b <= rom_fn(int'(rom_addr_b));

  initial forever begin
    @(posedge clk); #1;
    if (pa_req && ram_req_a && ram_addr_a !== pa_addr) stab_err++;
    pa_req = ram_req_a; pa_addr = ram_addr_a;
    if (late_a) late_cnt++;
    if (ram_valid_a) ram_valid_a = 1'b0;
    else if (ram_req_a) begin
      if (cnt_a >= dly_a) begin ram_valid_a = 1'b1; ram_rdata_a = ram_fn(ram_addr_a); cnt_a = 0; end
      else cnt_a++;
    end
  end
  initial forever begin
    @(posedge clk); #1;
    if (pb_req && ram_req_b && ram_addr_b !== pb_addr) stab_err++;
    pb_req = ram_req_b; pb_addr = ram_addr_b;
    if (ram_valid_b) ram_valid_b = 1'b0;
    else if (ram_req_b) begin
      if (cnt_b >= dly_b) begin ram_valid_b = 1'b1; ram_rdata_b = ram_fn(ram_addr_b); cnt_b = 0; end
      else cnt_b++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic pulse_a(input int r);
    row_a = 9'(r); line_start_a = 1'b1; @(negedge clk); line_start_a = 1'b0;
  endtask
  task automatic wait_idle_a();
    for (int i = 0; i < 5000 && busy_a; i++) @(negedge clk);
    chk("fill_done_a", 32'(busy_a), 0);
  endtask
  task automatic show_a(input int r);
    for (int c = 0; c < 224; c++) begin
      pix_col_a = 10'(c); @(negedge clk);
      chk($sformatf("col_a r%0d c%0d", r, c), 32'(ci_a), 32'(exp_ci(8, 28, 2, r, c)));
    end
  endtask
  task automatic run_a(input int r, input int d);
    wait_idle_a(); dly_a = d; pulse_a(r); wait_idle_a(); pulse_a(r); show_a(r);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc0, bdrop;
    repeat (3) @(negedge clk);
    chk("rst_ram_req", 32'(ram_req_a), 0);
    chk("rst_ram_addr", 32'(ram_addr_a), 0);
    chk("rst_rom_addr", 32'(rom_addr_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_line_late", 32'(late_a), 0);
    chk("rst_color", 32'(ci_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_a(16);
    chk("busy_after_start", 32'(busy_a), 1);
    chk("first_tile_addr", 32'(ram_addr_a), 0);
    @(negedge clk);
    chk("first_tile_addr", 32'(ram_addr_a), 32'h4038);
    wait_idle_a();
    pulse_a(16);
    for (int c = 0; c < 8; c++) begin
      pix_col_a = 10'(c); @(negedge clk);
      chk($sformatf("hand_pix c%0d", c), 32'(ci_a), 32'(hand[c]));
    end
    pix_col_a = 10'd3; blank_a = 1'b1; @(negedge clk);
    chk("blank", 32'(ci_a), 0);
    blank_a = 1'b0; pix_col_a = 10'd224; @(negedge clk);
    chk("col_224", 32'(ci_a), 0);
    pix_col_a = 10'd223; @(negedge clk);
    chk("col_223", 32'(ci_a), 32'(exp_ci(8, 28, 2, 16, 223)));
    run_a(16, 0);
    run_a(16, 1);
    run_a(16, 7);
    run_a(45, 3);
    // restart at tile 10 with an outstanding request
    wait_idle_a(); dly_a = 1; pulse_a(8);
    for (int i = 0; i < 3000 && !(ram_req_a && ram_addr_a == 16'h4026); i++) @(negedge clk);
    chk("tile10_seen", 32'(ram_req_a && ram_addr_a == 16'h4026), 1);
    lc0 = late_cnt;
    pulse_a(24);
    chk("late_pulse", 32'(late_a), 1);
    chk("busy_on_restart", 32'(busy_a), 1);
    @(negedge clk);
    chk("late_one_cycle", 32'(late_a), 0);
    bdrop = 0;
    for (int i = 0; i < 100 && !(ram_req_a && ram_addr_a == 16'h4054); i++) begin
      bdrop += int'(!busy_a); @(negedge clk);
    end
    chk("restart_addr", 32'(ram_req_a && ram_addr_a == 16'h4054), 1);
    chk("busy_held", 32'(bdrop), 0);
    chk("late_once", 32'(late_cnt - lc0), 1);
    wait_idle_a(); pulse_a(24); show_a(24);
    // reset while reading the tile ROM
    wait_idle_a(); dly_a = 0; pix_col_a = 10'd0; pulse_a(16);
    for (int i = 0; i < 100 && rom_addr_a != 12'd81; i++) @(negedge clk);
    chk("in_rd_rom", 32'(rom_addr_a), 81);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("mid_rst_ram_req", 32'(ram_req_a), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_color", 32'(ci_a), 0);
    run_a(45, 2);
    chk("addr_stable", 32'(stab_err), 0);
    // wide-tile variant
    row_b = 9'd20; line_start_b = 1'b1; @(negedge clk); line_start_b = 1'b0;
    for (int i = 0; i < 3000 && busy_b; i++) @(negedge clk);
    chk("fill_done_b", 32'(busy_b), 0);
    line_start_b = 1'b1; @(negedge clk); line_start_b = 1'b0;
    for (int c = 0; c < 64; c++) begin
      pix_col_b = 10'(c); @(negedge clk);
      chk($sformatf("col_b c%0d", c), 32'(ci_b), 32'(exp_ci(16, 4, 4, 20, c)));
    end
    pix_col_b = 10'd64; @(negedge clk);
    chk("col_b_64", 32'(ci_b), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
